xfcp_mgt_tx_framer: RTL and testbench
=====================================

Name: xfcp_mgt_tx_framer

Overview:
- Downstream of fpga_core on the XFCP MGT path: consumes the 8-bit XFCP AXI stream (xfcp_mgt_down_*) and produces 32-bit 8b/10b GTY transmit words with per-lane K flags.
- Packs bytes into 4-lane words, brackets frames with SOF/EOF control characters, fills gaps with pad characters, outputs idle between frames and inserts periodic clock-correction words.
- Emits one output word every clock.

Parameters:
- CC_INTERVAL, 1024: cycles between clock-correction words (>=8).
- FLUSH_TIMEOUT, 16: idle cycles mid-frame before a partial word is padded and emitted (>=1).

Ports:
- clk  in  1  clock (GT TX user clock domain)
- rst  in  1  asynchronous active-high reset
- s_axis_tdata  in  8  XFCP byte
- s_axis_tvalid  in  1  byte valid
- s_axis_tready  out  1  byte accepted when tvalid&tready
- s_axis_tlast  in  1  last byte of frame
- s_axis_tuser  in  1  frame error, sampled only with tlast
- gt_txdata  out  32  lane0 = [7:0], transmitted first
- gt_txcharisk  out  4  bit i = lane i is a K character
- busy  out  1  high while state != IDLE

Behaviour:
- Characters: SOF K27.7 0xFB; EOF K29.7 0xFD; error EOF K30.7 0xFE; pad K23.7 0xF7; CC K28.0 0x1C. Idle word = 0x505050BC, charisk 4'b0001.
- Reset (async): state IDLE, staging count n=0, CC counter 0, CC pending 0. gt_txdata=0x505050BC, gt_txcharisk=4'b0001, s_axis_tready=0, busy=0. Reset mid-frame drops the partial frame without emitting an EOF.
- Staging register: 4 lanes plus K flags; n ranges 0..4. A word is "complete" when all 4 lanes are filled. A complete word appears on gt_txdata the cycle after completion, then n=0.
- State IDLE: tready=0. On tvalid, stage SOF in lane0 (n=1) and go to DATA. The first byte is not accepted in the SOF cycle.
- State DATA: tready=1. An accepted byte goes to lane n.
  - tlast with n<=2: stage EOF (0xFE if tuser) at lane n+1, pad the remaining lanes, complete the word, go to IDLE.
  - tlast with n==3: the byte completes the word; go to EOF.
  - Flush counter: resets on every accepted byte. If n>0 and no byte is accepted for FLUSH_TIMEOUT consecutive cycles, pad the remaining lanes and complete the word.
- State EOF: tready=0. Stage {pad,pad,pad,EOF/errEOF}, charisk 4'b1111, complete the word, go to IDLE. The EOF type is the tuser value latched with tlast.
- Output select each cycle, in priority order:
  1. Complete staged word.
  2. CC word 0x1C1C1C1C, charisk 4'b1111, if CC pending.
  3. Pad word 0xF7F7F7F7, charisk 4'b1111, if busy.
  4. Otherwise the idle word.
- A data word never waits: at most one word completes per cycle.
- CC counter: increments every cycle. At CC_INTERVAL-1 it sets pending and wraps to 0. Pending clears when the CC word is output. A CC deferred by a data word goes out the next cycle. A CC may appear mid-frame; the receiver discards K28.0.
- tdata/tuser are ignored when tvalid=0. tuser on non-last bytes is ignored.
- Zero-length frames are impossible: the first byte after SOF always carries the data.

Optional Feature:
- Macro XFCP_MGT_TX_STATS_EN.
- Defined: adds outputs stat_frames[31:0] (+1 per EOF/errEOF emitted) and stat_err_frames[15:0] (+1 per errEOF). Both are reset to 0, wrap on overflow, and update the cycle the word is output.
- Undefined: these ports and their counters are absent. All other behaviour is identical.

Test Plan:
- Reset -> gt_txdata=0x505050BC, charisk=0001, tready=0, busy=0; asserting rst mid-frame gives the same values immediately.
- Back-to-back frame 0x11,0x22,0x33 (tlast on 0x33, tuser=0) -> words {0x332211FB, charisk 0001} then {0xFDF7F7F7, charisk 1111}, then idle; tready low in the SOF and EOF cycles.
- Frame 0xA1,0xA2 (tlast+tuser on 0xA2) -> single word 0xFEA2A1FB, charisk 1001; with XFCP_MGT_TX_STATS_EN defined, stat_frames=1 and stat_err_frames=1.
- FLUSH_TIMEOUT=4: SOF+0x01, then tvalid low for 4 cycles -> word 0xF7F701FB, charisk 1101, pad words before and after. A following 0x02 with tlast -> 0xF7F7FD02, charisk 1110.
- CC_INTERVAL=16 while idle -> 0x1C1C1C1C, charisk 1111, every 16th cycle, idle words otherwise.
- CC coincides with a data-word completion -> data word first, CC word the next cycle, next CC 16 cycles after that.

Source files
------------

// File: rtl/xfcp_mgt_tx_framer_if.sv
// XFCP byte stream handshake bundle for the MGT transmit framer.
// Signals: tdata[7:0], tvalid, tready, tlast, tuser (frame error, with tlast).
interface xfcp_mgt_tx_framer_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/xfcp_mgt_tx_framer.sv
// XFCP MGT transmit framer: packs the XFCP byte stream into 32-bit 8b/10b words
// with SOF/EOF framing, pad fill, idle words and periodic clock correction.
// Ports: clk, rst (async, active high), s_axis (slave byte stream),
// gt_txdata[31:0] (lane0 = [7:0]), gt_txcharisk[3:0], busy.
// Optional macro XFCP_MGT_TX_STATS_EN adds stat_frames[31:0], stat_err_frames[15:0].
module xfcp_mgt_tx_framer #(
    parameter int CC_INTERVAL   = 1024,
    parameter int FLUSH_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    xfcp_mgt_tx_framer_if.slave  s_axis,
    output logic [31:0]          gt_txdata,
    output logic [3:0]           gt_txcharisk,
    output logic                 busy
`ifdef XFCP_MGT_TX_STATS_EN
    ,
    output logic [31:0]          stat_frames,
    output logic [15:0]          stat_err_frames
`endif
);

    localparam logic [7:0]  K_SOF  = 8'hFB;
    localparam logic [7:0]  K_EOF  = 8'hFD;
    localparam logic [7:0]  K_ERR  = 8'hFE;
    localparam logic [7:0]  K_PAD  = 8'hF7;
    localparam logic [31:0] W_CC   = 32'h1C1C1C1C;
    localparam logic [31:0] W_PAD  = 32'hF7F7F7F7;
    localparam logic [31:0] W_IDLE = 32'h505050BC;
    localparam int FW = $clog2(FLUSH_TIMEOUT + 1);
    localparam int CW = $clog2(CC_INTERVAL);

    typedef enum logic [1:0] {IDLE, DATA, EOF} state_t;

    state_t          state, state_d;
    logic [3:0][7:0] lane_q, lane_d;
    logic [3:0]      k_q, k_d;
    logic [2:0]      n_q, n_d;
    logic [FW-1:0]   fl_q, fl_d;
    logic            err_q, err_d;
    logic            done, done_eof, done_err;
    logic [CW-1:0]   cc_q;
    logic            ccp_q, cc_hit, cc_sent;
    logic [31:0]     out_data;
    logic [3:0]      out_k;
    logic            accept;
    logic [1:0]      ln;

    assign s_axis.tready = (state == DATA);
    assign busy          = (state != IDLE);
    assign accept        = (state == DATA) && s_axis.tvalid;
    assign ln            = n_q[1:0];
    assign cc_hit        = (cc_q == CW'(CC_INTERVAL - 1));

    always_comb begin
        state_d  = state;
        lane_d   = lane_q;
        k_d      = k_q;
        n_d      = n_q;
        fl_d     = fl_q;
        err_d    = err_q;
        done     = 1'b0;
        done_eof = 1'b0;
        done_err = 1'b0;
        unique case (state)
            IDLE: begin
                fl_d = '0;
                if (s_axis.tvalid) begin
                    lane_d[0] = K_SOF;
                    k_d       = 4'b0001;
                    n_d       = 3'd1;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (accept) begin
                    fl_d       = '0;
                    lane_d[ln] = s_axis.tdata;
                    k_d[ln]    = 1'b0;
                    n_d        = n_q + 3'd1;
                    if (s_axis.tlast) begin
                        if (n_q == 3'd3) begin
                            // word is full of data; EOF follows in its own word
                            done    = 1'b1;
                            err_d   = s_axis.tuser;
                            state_d = EOF;
                        end else begin
                            lane_d[ln + 2'd1] = s_axis.tuser ? K_ERR : K_EOF;
                            k_d[ln + 2'd1]    = 1'b1;
                            for (int i = 0; i < 4; i++) begin
                                if (i > int'(n_q) + 1) begin
                                    lane_d[i] = K_PAD;
                                    k_d[i]    = 1'b1;
                                end
                            end
                            done     = 1'b1;
                            done_eof = 1'b1;
                            done_err = s_axis.tuser;
                            state_d  = IDLE;
                        end
                    end else if (n_q == 3'd3) begin
                        done = 1'b1;
                    end
                end else if (n_q != 3'd0 && fl_q == FW'(FLUSH_TIMEOUT - 1)) begin
                    // stalled source: push out the partial word
                    for (int i = 0; i < 4; i++) begin
                        if (i >= int'(n_q)) begin
                            lane_d[i] = K_PAD;
                            k_d[i]    = 1'b1;
                        end
                    end
                    done = 1'b1;
                    fl_d = '0;
                end else if (fl_q != FW'(FLUSH_TIMEOUT - 1)) begin
                    fl_d = fl_q + FW'(1);
                end
            end
            EOF: begin
                lane_d   = {(err_q ? K_ERR : K_EOF), K_PAD, K_PAD, K_PAD};
                k_d      = 4'b1111;
                done     = 1'b1;
                done_eof = 1'b1;
                done_err = err_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (done) n_d = 3'd0;
    end

    always_comb begin
        out_data = W_IDLE;
        out_k    = 4'b0001;
        cc_sent  = 1'b0;
        if (done) begin
            out_data = lane_d;
            out_k    = k_d;
        end else if (ccp_q) begin
            out_data = W_CC;
            out_k    = 4'b1111;
            cc_sent  = 1'b1;
        end else if (busy) begin
            out_data = W_PAD;
            out_k    = 4'b1111;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            lane_q       <= '0;
            k_q          <= '0;
            n_q          <= '0;
            fl_q         <= '0;
            err_q        <= 1'b0;
            cc_q         <= '0;
            ccp_q        <= 1'b0;
            gt_txdata    <= W_IDLE;
            gt_txcharisk <= 4'b0001;
        end else begin
            state        <= state_d;
            lane_q       <= lane_d;
            k_q          <= k_d;
            n_q          <= n_d;
            fl_q         <= fl_d;
            err_q        <= err_d;
            cc_q         <= cc_hit ? '0 : cc_q + CW'(1);
            // a new request wins over a clear in the same cycle
            ccp_q        <= cc_hit | (ccp_q & ~cc_sent);
            gt_txdata    <= out_data;
            gt_txcharisk <= out_k;
        end
    end

`ifdef XFCP_MGT_TX_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_frames     <= '0;
            stat_err_frames <= '0;
        end else begin
            if (done_eof) stat_frames <= stat_frames + 32'd1;
            if (done_err) stat_err_frames <= stat_err_frames + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_xfcp_mgt_tx_framer.sv
// Self-checking bench for xfcp_mgt_tx_framer: directed frames plus random
// traffic compared against a queue-based character stream model.
module tb_xfcp_mgt_tx_framer;

    localparam int CI = 16;
    localparam int FT = 4;
    localparam logic [31:0] W_IDLE = 32'h505050BC;
    localparam logic [31:0] W_CC   = 32'h1C1C1C1C;
    localparam logic [31:0] W_PAD  = 32'hF7F7F7F7;
    localparam logic [8:0]  C_SOF  = {1'b1, 8'hFB};
    localparam logic [8:0]  C_EOF  = {1'b1, 8'hFD};
    localparam logic [8:0]  C_ERR  = {1'b1, 8'hFE};
    localparam logic [8:0]  C_PAD  = {1'b1, 8'hF7};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] gt_txdata;
    logic [3:0]  gt_txcharisk;
    logic        busy;
`ifdef XFCP_MGT_TX_STATS_EN
    logic [31:0] stat_frames;
    logic [15:0] stat_err_frames;
`endif

    xfcp_mgt_tx_framer_if s_if ();

    xfcp_mgt_tx_framer #(.CC_INTERVAL(CI), .FLUSH_TIMEOUT(FT)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis       (s_if.slave),
        .gt_txdata    (gt_txdata),
        .gt_txcharisk (gt_txcharisk),
        .busy         (busy)
`ifdef XFCP_MGT_TX_STATS_EN
        ,
        .stat_frames     (stat_frames),
        .stat_err_frames (stat_err_frames)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // model: 0 = between frames, 1 = in frame, 2 = EOF word owed
    int          m_st;
    logic [8:0]  q[$];
    int          quiet;
    int          ccc;
    bit          ccp;
    bit          m_err;
    logic [31:0] e_data;
    logic [3:0]  e_k;
    int          e_frames;
    int          e_errs;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s obs=%08h exp=%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; q.delete(); quiet = 0; ccc = 0; ccp = 0; m_err = 0;
        e_data = W_IDLE; e_k = 4'b0001; e_frames = 0; e_errs = 0;
    endtask

    task automatic model_clock(input bit tv, input logic [7:0] td,
                               input bit tl, input bit tu);
        bit was_busy = (m_st != 0);
        bit eof_w = 0;
        bit err_w = 0;
        bit sent = 0;
        case (m_st)
            0: if (tv) begin
                q.delete(); q.push_back(C_SOF); m_st = 1; quiet = 0;
            end
            1: if (tv) begin
                quiet = 0;
                q.push_back({1'b0, td});
                if (tl) begin
                    if (q.size() == 4) begin
                        m_st = 2; m_err = tu;
                    end else begin
                        q.push_back(tu ? C_ERR : C_EOF);
                        while (q.size() < 4) q.push_back(C_PAD);
                        eof_w = 1; err_w = tu; m_st = 0;
                    end
                end
            end else begin
                quiet++;
                if (q.size() > 0 && quiet >= FT) begin
                    while (q.size() < 4) q.push_back(C_PAD);
                    quiet = 0;
                end
            end
            default: begin
                q.delete();
                q.push_back(C_PAD); q.push_back(C_PAD); q.push_back(C_PAD);
                q.push_back(m_err ? C_ERR : C_EOF);
                eof_w = 1; err_w = m_err; m_st = 0;
            end
        endcase
        if (q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                e_data[8*i +: 8] = q[i][7:0];
                e_k[i] = q[i][8];
            end
            q.delete();
            e_frames += int'(eof_w);
            e_errs   += int'(err_w);
        end else if (ccp) begin
            e_data = W_CC; e_k = 4'b1111; sent = 1;
        end else if (was_busy) begin
            e_data = W_PAD; e_k = 4'b1111;
        end else begin
            e_data = W_IDLE; e_k = 4'b0001;
        end
        if (sent) ccp = 0;
        if (ccc == CI - 1) begin
            ccc = 0; ccp = 1;
        end else begin
            ccc++;
        end
    endtask

    task automatic step(input bit tv, input logic [7:0] td, input bit tl,
                        input bit tu, output bit acc);
        s_if.tvalid = tv; s_if.tdata = td; s_if.tlast = tl; s_if.tuser = tu;
        @(negedge clk);
        check("tready", {31'd0, s_if.tready}, {31'd0, (m_st == 1)});
        acc = (m_st == 1) && tv;
        @(posedge clk);
        model_clock(tv, td, tl, tu);
        #1;
        cyc++;
        check("txdata", gt_txdata, e_data);
        check("charisk", {28'd0, gt_txcharisk}, {28'd0, e_k});
        check("busy", {31'd0, busy}, {31'd0, (m_st != 0)});
`ifdef XFCP_MGT_TX_STATS_EN
        check("stat_frames", stat_frames, e_frames);
        check("stat_err", {16'd0, stat_err_frames}, e_errs);
`endif
    endtask

    task automatic do_reset();
        s_if.tvalid = 0; s_if.tlast = 0; s_if.tuser = 0; s_if.tdata = 0;
        rst = 1;
        #1;
        check("rst_data", gt_txdata, W_IDLE);
        check("rst_k", {28'd0, gt_txcharisk}, 32'd1);
        check("rst_tready", {31'd0, s_if.tready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
`ifdef XFCP_MGT_TX_STATS_EN
        check("rst_stat", stat_frames, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        cyc = 0;
    endtask

    initial begin
        bit acc;
        bit tv, tl, tu;
        logic [7:0] td;
        int pct;
        s_if.tvalid = 0; s_if.tlast = 0; s_if.tuser = 0; s_if.tdata = 0;
        @(posedge clk);
        #1;
        do_reset();

        // three-byte frame, EOF in its own word
        step(1, 8'h11, 0, 0, acc);
        step(1, 8'h11, 0, 0, acc);
        step(1, 8'h22, 0, 0, acc);
        step(1, 8'h33, 1, 0, acc);
        check("w1_data", gt_txdata, 32'h332211FB);
        check("w1_k", {28'd0, gt_txcharisk}, 32'h1);
        step(0, 8'h00, 0, 0, acc);
        check("w2_data", gt_txdata, 32'hFDF7F7F7);
        check("w2_k", {28'd0, gt_txcharisk}, 32'hF);
        step(0, 8'h00, 0, 0, acc);
        check("idle_after", gt_txdata, W_IDLE);

        // two-byte error frame in one word
        do_reset();
        step(1, 8'hA1, 0, 0, acc);
        step(1, 8'hA1, 0, 0, acc);
        step(1, 8'hA2, 1, 1, acc);
        check("err_data", gt_txdata, 32'hFEA2A1FB);
        check("err_k", {28'd0, gt_txcharisk}, 32'h9);
`ifdef XFCP_MGT_TX_STATS_EN
        check("err_frames", stat_frames, 32'd1);
        check("err_errs", {16'd0, stat_err_frames}, 32'd1);
`endif

        // flush of a partial word after FT quiet cycles
        do_reset();
        step(1, 8'h01, 0, 0, acc);
        step(1, 8'h01, 0, 0, acc);
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h00, 0, 0, acc);
            check("pre_flush_pad", gt_txdata, W_PAD);
        end
        step(0, 8'h00, 0, 0, acc);
        check("flush_data", gt_txdata, 32'hF7F701FB);
        check("flush_k", {28'd0, gt_txcharisk}, 32'hD);
        step(0, 8'h00, 0, 0, acc);
        check("post_flush_pad", gt_txdata, W_PAD);
        step(1, 8'h02, 1, 0, acc);
        check("tail_data", gt_txdata, 32'hF7F7FD02);
        check("tail_k", {28'd0, gt_txcharisk}, 32'hE);

        // periodic CC while idle
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            step(0, 8'h00, 0, 0, acc);
            check("cc_idle", gt_txdata,
                  (k > 1 && k % CI == 1) ? W_CC : W_IDLE);
        end

        // CC deferred by a data word
        do_reset();
        for (int k = 0; k < 13; k++) step(0, 8'h00, 0, 0, acc);
        step(1, 8'h11, 0, 0, acc);
        step(1, 8'h11, 0, 0, acc);
        step(1, 8'h22, 0, 0, acc);
        step(1, 8'h33, 0, 0, acc);
        check("cc_col_word", gt_txdata, 32'h332211FB);
        step(0, 8'h00, 0, 0, acc);
        check("cc_col_cc", gt_txdata, W_CC);
        step(1, 8'h44, 1, 0, acc);
        check("cc_col_tail", gt_txdata, 32'hF7F7FD44);
        while (cyc < 32) step(0, 8'h00, 0, 0, acc);
        check("cc_col_pre", gt_txdata, W_IDLE);
        step(0, 8'h00, 0, 0, acc);
        check("cc_col_next", gt_txdata, W_CC);

        // reset in the middle of a frame
        do_reset();
        step(1, 8'h55, 0, 0, acc);
        step(1, 8'h55, 0, 0, acc);
        step(1, 8'h66, 0, 0, acc);
        do_reset();

        // random traffic with AXI hold rules
        acc = 1; tv = 0; tl = 0; tu = 0; td = 0; pct = 60;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0: pct = 90;
                    1: pct = 50;
                    default: pct = 10;
                endcase
            end
            if (i == 1500) begin
                do_reset();
                acc = 1;
            end
            if (!(tv && !acc)) begin
                tv = ($urandom_range(0, 99) < pct);
                td = 8'($urandom);
                tl = ($urandom_range(0, 4) == 0);
                tu = ($urandom_range(0, 3) == 0);
            end
            step(tv, td, tl, tu, acc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
